// File: rtl/dmem_lane_ctrl.sv
// dmem_lane_ctrl: data-memory controller for the multicycle MIPS core.
// It owns a word-organised RAM and takes one request at a time over a
// valid/ready channel. Stores may be byte, half or word wide. Loads are
// sign- or zero-extended. Each request is answered by a one-cycle
// response pulse that carries the load data and an error flag.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   req_valid/ready     request handshake; ready only while idle
//   req_we              1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        load extension: 1 = zero, 0 = sign
//   req_addr, req_wdata byte address and right-justified store data
//   rsp_valid           one-cycle pulse, LATENCY+1 cycles after accept
//   rsp_rdata, rsp_err  extended load data, and error flag for
//                       misaligned, out-of-range or illegal-size requests

// Byte-lane merge for the read-modify-write of the addressed word.
module dmem_lane_ctrl_lane (
    input  logic [7:0] old_byte,
    input  logic [7:0] new_byte,
    input  logic       en,
    output logic [7:0] merged
);
    assign merged = en ? new_byte : old_byte;
endmodule

module dmem_lane_ctrl #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int         AW        = $clog2(DEPTH);
    localparam int         NUM_LANES = 4;
    localparam logic [3:0] LAT_LAST  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        ready_q;
    logic        accept;
    logic        enter_resp;
    req_t        req_in, req_q, acc;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0]                 word_idx;
    logic [1:0]                    lane;
    logic                          err;
    logic [NUM_LANES-1:0]          be;
    logic [31:0]                   wlanes;
    logic [31:0]                   rd_word;
    logic [31:0]                   shifted;
    logic [31:0]                   ld_data;
    logic [NUM_LANES-1:0][7:0]     merged;

    assign req_in    = '{we: req_we, size: req_size, uns: req_unsigned,
                         addr: req_addr, wdata: req_wdata};
    assign req_ready = ready_q;
    assign accept    = req_valid & ready_q;
    assign rsp_valid = (state == RESP);

    // With LATENCY=0 the array access happens on the accept edge itself,
    // so the live request fields are used while idle.
    assign acc = (state == IDLE) ? req_in : req_q;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nxt = '0;
                    if (LATENCY == 0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == LAT_LAST) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address decode and error detection.
    assign word_idx = acc.addr[AW+1:2];
    assign lane     = acc.addr[1:0];

    always_comb begin
        err = |acc.addr[31:AW+2];
        case (acc.size)
            2'b00:   err = err;
            2'b01:   err = err | acc.addr[0];
            2'b10:   err = err | (|acc.addr[1:0]);
            default: err = 1'b1;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone
    // pick what lands where.
    always_comb begin
        be     = '0;
        wlanes = acc.wdata;
        case (acc.size)
            2'b00: begin
                be     = 4'b0001 << lane;
                wlanes = {4{acc.wdata[7:0]}};
            end
            2'b01: begin
                be     = 4'b0011 << {lane[1], 1'b0};
                wlanes = {2{acc.wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = '0;
        endcase
    end

    assign rd_word = mem[word_idx];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        dmem_lane_ctrl_lane u_lane (
            .old_byte (rd_word[g*8 +: 8]),
            .new_byte (wlanes[g*8 +: 8]),
            .en       (be[g]),
            .merged   (merged[g])
        );
    end

    // Load path: move the addressed lane down to bit 0, then extend.
    assign shifted = rd_word >> {lane, 3'b000};

    always_comb begin
        ld_data = rd_word;
        case (acc.size)
            2'b00:   ld_data = acc.uns ? {24'd0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ld_data = acc.uns ? {16'd0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_data = rd_word;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ready_q   <= 1'b0;
            req_q     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            // Registered so that ready stays low during reset and for the
            // first cycle after release.
            ready_q <= (state_nxt == IDLE);
            if (accept)
                req_q <= req_in;
            if (enter_resp) begin
                rsp_err   <= err;
                rsp_rdata <= (err | acc.we) ? 32'd0 : ld_data;
            end
        end
    end

    // The array is not reset. During reset the FSM is held idle with ready
    // low, so a store that was still pending is never committed.
    always_ff @(posedge clk) begin
        if (enter_resp && acc.we && !err)
            mem[word_idx] <= merged;
    end

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
module tb_dmem_lane_ctrl;
    localparam int DEPTH = 64;
    localparam int LAT   = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        rdy_l0, rv_l0, er_l0;
    logic [31:0] rd_l0;
    logic        rdy_l5, rv_l5, er_l5;
    logic [31:0] rd_l5;

    int ncmp = 0;
    int nerr = 0;
    logic [7:0] mbytes [DEPTH*4];

    always #5 clk = ~clk;

    dmem_lane_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

    dmem_lane_ctrl #(.DEPTH(DEPTH), .LATENCY(0)) u_l0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_l0),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv_l0),
        .rsp_rdata(rd_l0), .rsp_err(er_l0));

    dmem_lane_ctrl #(.DEPTH(DEPTH), .LATENCY(5)) u_l5 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_l5),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv_l5),
        .rsp_rdata(rd_l5), .rsp_err(er_l5));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Byte-addressed reference memory.
    function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rd, output logic err);
        int nb;
        logic [31:0] val;
        nb  = 1 << size;
        err = (size == 2'd3) || ((addr % nb) != 0) || ((addr / 4) >= DEPTH);
        rd  = '0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < nb; i++) mbytes[int'(addr) + i] = wdata[8*i +: 8];
        end else begin
            val = '0;
            for (int i = 0; i < nb; i++) val[8*i +: 8] = mbytes[int'(addr) + i];
            if (!uns && nb < 4 && val[8*nb-1])
                for (int i = nb; i < 4; i++) val[8*i +: 8] = 8'hFF;
            rd = val;
        end
    endfunction

    // Called on a negedge; returns on the negedge of the response cycle
    // (keep=1) or one cycle later after checking the pulse width (keep=0).
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit keep, output logic [31:0] got);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          cyc;
        bit          seen;
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        got = '0;
        cyc = 0;
        while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
        chk("accept_wait", {31'd0, req_ready}, 32'd1);
        if (!req_ready) begin req_valid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
        model(we, size, uns, addr, wdata, exp_rd, exp_err);
        cyc = 1; seen = 0;
        while (cyc <= 40) begin
            if (rsp_valid) begin seen = 1; break; end
            chk("ready_low_busy", {31'd0, req_ready}, 32'd0);
            @(negedge clk); cyc++;
        end
        chk("rsp_seen", {31'd0, seen}, 32'd1);
        chk("rsp_latency", 32'(cyc), 32'(LAT + 1));
        chk("ready_low_rsp", {31'd0, req_ready}, 32'd0);
        chk($sformatf("rdata@%0h", addr), rsp_rdata, exp_rd);
        chk($sformatf("err@%0h", addr), {31'd0, rsp_err}, {31'd0, exp_err});
        got = rsp_rdata;
        if (!keep) begin
            @(negedge clk);
            chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [1:0]  sz;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {31'd0, req_ready}, 32'd1);

        // Give every word a known value
        for (int i = 0; i < DEPTH; i++) issue(1'b1, 2'b10, 1'b0, 32'(i*4), $urandom, 1'b0, got);

        // Reset in the middle of a store's wait phase
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
            chk("midrst_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_midrst", {31'd0, req_ready}, 32'd1);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, got);

        // Byte lanes
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0, got);
        issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h555555AA, 1'b0, got);
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, got);
        chk("lw_0x20", got, 32'h1122AA44);
        issue(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1'b0, got);
        chk("lb_0x21", got, 32'hFFFFFFAA);
        issue(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b0, got);
        chk("lbu_0x21", got, 32'h000000AA);

        // Halves
        issue(1'b1, 2'b01, 1'b0, 32'h32, 32'hABCD8001, 1'b0, got);
        issue(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 1'b0, got);
        chk("lh_0x32", got, 32'hFFFF8001);
        issue(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 1'b0, got);
        chk("lhu_0x32", got, 32'h00008001);
        issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, got);
        chk("lw_0x30_upper", {16'd0, got[31:16]}, 32'h00008001);

        // Errors, followed by readback of the would-be targets
        issue(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1'b0, got);
        issue(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1'b0, got);
        issue(1'b1, 2'b11, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, got);
        issue(1'b1, 2'b01, 1'b0, 32'h21, 32'h0000BEEF, 1'b0, got);
        issue(1'b1, 2'b10, 1'b0, 32'(DEPTH*4), 32'h12345678, 1'b0, got);
        issue(1'b0, 2'b10, 1'b0, 32'(DEPTH*4), 32'h0, 1'b0, got);
        issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, got);
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, got);
        chk("lw_0x20_after_err", got, 32'h1122AA44);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, DEPTH*4 - 1));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~(32'((1 << sz) - 1));
            if ($urandom_range(0, 15) == 0) a = $urandom;
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, got);
        end

        // Back-to-back with req_valid held high
        for (int k = 0; k < 8; k++) begin
            a = 32'(4 * (k / 2) + 32'h80);
            issue(1'(k % 2 == 0), 2'b10, 1'b0, a, $urandom, 1'b1, got);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("b2b_no_extra_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        // Latency sweep across LATENCY = 0, 1, 5 from a single shared accept
        repeat (20) @(negedge clk);
        chk("sweep_rdy_l0", {31'd0, rdy_l0}, 32'd1);
        chk("sweep_rdy_l1", {31'd0, req_ready}, 32'd1);
        chk("sweep_rdy_l5", {31'd0, rdy_l5}, 32'd1);
        req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            chk($sformatf("sweep_rv_l0_c%0d", c), {31'd0, rv_l0}, {31'd0, c == 1});
            chk($sformatf("sweep_rv_l1_c%0d", c), {31'd0, rsp_valid}, {31'd0, c == 2});
            chk($sformatf("sweep_rv_l5_c%0d", c), {31'd0, rv_l5}, {31'd0, c == 6});
            chk($sformatf("sweep_rdy_l0_c%0d", c), {31'd0, rdy_l0}, {31'd0, c > 1});
            chk($sformatf("sweep_rdy_l1_c%0d", c), {31'd0, req_ready}, {31'd0, c > 2});
            chk($sformatf("sweep_rdy_l5_c%0d", c), {31'd0, rdy_l5}, {31'd0, c > 6});
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/dmem_lane_ctrl.md
Name: dmem_lane_ctrl

Overview:
Parametrised data-memory controller for the multicycle MIPS. Generalises the single store-byte data memory to byte/half/word stores, sign- or zero-extended loads, configurable depth and access latency. Uses a valid/ready request channel and a one-cycle response pulse, with alignment and range error reporting. Sits between the core's load/store unit and the word-organised RAM array it owns internally.

Parameters:
DEPTH, 64, number of 32-bit words in the array (power of 2, 4..4096)
LATENCY, 1, extra wait cycles between request accept and response (0..15)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
req_valid  input  1  request present
req_ready  output  1  controller can accept request this cycle
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores and words
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  request was misaligned, out of range or illegal size

Behaviour:
- Reset (reset=0, async): FSM to IDLE; req_ready=0 while in reset, 1 in IDLE after release; rsp_valid=0, rsp_rdata=0, rsp_err=0; wait counter=0. Array contents not reset.
- Reset mid-transaction: request dropped, pending store NOT committed, no response.
- FSM: IDLE -> (accept) WAIT if LATENCY>0 else RESP; WAIT counts LATENCY cycles -> RESP; RESP -> IDLE after one cycle.
- req_ready=1 only in IDLE. Accept = req_valid & req_ready at clock edge; all req_* fields registered at accept; inputs ignored afterwards.
- Latency: rsp_valid high exactly LATENCY+1 cycles after the accept edge, for exactly one cycle; no response back-pressure. Max throughput one request per LATENCY+2 cycles.
- Array access (read and write) occurs on the edge that enters RESP; rsp_rdata/rsp_err registered on that same edge and held until next response or reset (only meaningful with rsp_valid).
- Word index = addr[log2(DEPTH)+1:2]. Little-endian lanes: byte lane = addr[1:0], half lane = addr[1].
- Error if: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0; addr[31:2] >= DEPTH. On error: no write, rsp_rdata=0, rsp_err=1.
- Stores: write only the addressed lane(s) (byte-enable); other bytes of the word unchanged; rsp_rdata=0, rsp_err=0.
- Loads: select lane, then extend to 32 bits per req_unsigned; word loads returned unmodified.
- req_valid deasserted while not ready: no effect; no request queuing.

Test Plan:
- Reset: assert reset=0 mid-WAIT of a store of 0xDEADBEEF to 0x10 -> no rsp_valid; after release load word 0x10 returns prior contents; req_ready=0 during reset, 1 one cycle after release.
- Byte lanes: sw 0x11223344 @0x20, sb 0xAA @0x21, lw @0x20 -> 0x1122AA44; lb @0x21 -> 0xFFFFFFAA; lbu @0x21 -> 0x000000AA.
- Halves: sh 0x8001 @0x32, lh @0x32 -> 0xFFFF8001, lhu -> 0x00008001; lw @0x30 shows upper half 0x8001, lower half unchanged.
- Errors: lh @0x21, lw @0x22, size=11 @0x0, lw @(DEPTH*4) -> each rsp_err=1, rsp_rdata=0, target words unchanged on readback.
- Latency sweep LATENCY=0,1,5: accept at cycle t -> rsp_valid only at t+LATENCY+1, one cycle; req_ready low from t+1 through response cycle.
- Back-to-back: req_valid held high with 8 alternating sw/lw requests -> each accepted only in IDLE, every lw returns the preceding sw data, no lost or duplicated responses.
